// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake and a 2-entry skid
// buffer. Writeback back-pressure only reaches the memory stage through the
// registered in_ready. Includes synchronous flush, control gating on empty
// slots and a saturating stall counter.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no entry held, accepting
// ST_BUSY  | main entry valid, accepting
// ST_FULL  | main + skid entries valid, not accepting
module mem_wb_pipe_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  ALU_result_M,
  input  logic [RA_W-1:0]  register_file_WA_M,
  input  logic [XLEN-1:0]  data_memory_RD_M,
  input  logic             ctrl_register_file_WE_M,
  input  logic             ctrl_result_M,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ALU_result_W,
  output logic [RA_W-1:0]  register_file_WA_W,
  output logic [XLEN-1:0]  data_memory_RD_W,
  output logic             ctrl_register_file_WE_W,
  output logic             ctrl_result_W,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [RA_W-1:0] wa;
    logic [XLEN-1:0] rd;
    logic            we;
    logic            res;
  } beat_t;

  state_t           state_q, state_d;
  beat_t            main_q, main_d;
  beat_t            skid_q, skid_d;
  beat_t            in_beat;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             acc;
  logic             xfer;

  assign in_beat = '{alu: ALU_result_M,
                     wa:  register_file_WA_M,
                     rd:  data_memory_RD_M,
                     we:  ctrl_register_file_WE_M,
                     res: ctrl_result_M};

  assign acc  = in_valid & in_ready_q;
  assign xfer = out_valid_q & out_ready;

  // Next-state and payload steering; flush overrides any transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_BUSY;
            main_d  = in_beat;
          end
        end
        ST_BUSY: begin
          if (acc && xfer) begin
            main_d = in_beat;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_d  = in_beat;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags are registered copies decoded from the next state, so
  // in_ready never depends combinationally on out_ready or in_valid.
  always_comb begin
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Saturating count of cycles where writeback holds off a live slot.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, payload and counter registers; in_ready stays low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Data follows the main entry; controls are masked when the slot is empty.
  always_comb begin
    in_ready                = in_ready_q;
    out_valid               = out_valid_q;
    ALU_result_W            = main_q.alu;
    register_file_WA_W      = main_q.wa;
    data_memory_RD_W        = main_q.rd;
    ctrl_register_file_WE_W = main_q.we & out_valid_q;
    ctrl_result_W           = main_q.res & out_valid_q;
    stall_cnt               = stall_cnt_q;
  end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
Parametrised MEM->WB pipeline register, the successor to the fixed-width unconditional MEM/WB latch. Carries the ALU result, writeback address, load data and writeback controls from memory stage to writeback stage. Adds a valid/ready handshake with a 2-entry skid buffer so writeback back-pressure never combinationally reaches the memory stage. Also adds synchronous flush, control gating on invalid slots and a saturating stall counter.

Parameters:
XLEN, 32, width of ALU result and load data
RA_W, 5, width of register-file write address
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  memory stage presents an instruction
in_ready  out  1  block can accept this cycle
ALU_result_M  in  XLEN  ALU result
register_file_WA_M  in  RA_W  destination register
data_memory_RD_M  in  XLEN  load data
ctrl_register_file_WE_M  in  1  register-file write enable
ctrl_result_M  in  1  result select (0 ALU, 1 memory)
out_valid  out  1  writeback slot holds a live instruction
out_ready  in  1  writeback stage consumes this cycle
ALU_result_W  out  XLEN  registered ALU result
register_file_WA_W  out  RA_W  registered destination
data_memory_RD_W  out  XLEN  registered load data
ctrl_register_file_WE_W  out  1  gated write enable
ctrl_result_W  out  1  gated result select
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset: asynchronous on rst_n low. Clears every register, including main and skid payloads, to 0, state to EMPTY and stall_cnt to 0. in_ready=0 while rst_n is low. All other outputs are 0.
- Storage: main entry drives the *_W outputs. Skid entry holds one overflow beat.
- acc = in_valid & in_ready. xfer = out_valid & out_ready.
- States:
  - EMPTY (no entries): out_valid=0, in_ready=1. acc -> BUSY, main<=in.
  - BUSY (main only): out_valid=1, in_ready=1.
    - acc & xfer -> BUSY, main<=in.
    - acc & !xfer -> FULL, skid<=in.
    - !acc & xfer -> EMPTY.
    - Otherwise hold.
  - FULL (main+skid): out_valid=1, in_ready=0. xfer -> BUSY, main<=skid. Otherwise hold.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready or in_valid to in_ready.
- Latency: 1 cycle from acc to out_valid when EMPTY, or when BUSY with a simultaneous xfer. Order is strictly FIFO. No beat is duplicated or dropped except by flush.
- Gating: ctrl_register_file_WE_W and ctrl_result_W are forced to 0 whenever out_valid=0. Data outputs hold their last value when invalid.
- flush: highest priority after reset. The next state is EMPTY regardless of acc or xfer. A same-cycle input is discarded. A same-cycle xfer still counts as consumed by downstream. Payload registers are not cleared.
- in_ready=0 while FULL. An input presented then is not accepted and must be held by upstream.
- stall_cnt increments on every cycle with out_valid & !out_ready. It saturates at 2^CNT_W-1 and never wraps. Only reset clears it; flush does not.

Test Plan:
- Reset release then stream: in_valid=1 with out_ready=1 held, ALU_result_M=0x11,0x22,0x33 -> the same values appear on ALU_result_W one cycle later each, out_valid=1 continuously, in_ready=1 throughout.
- Back-pressure: send 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0, ALU_result_W=0xA. Raise out_ready -> 0xA then 0xB are delivered in order, after which in_ready returns to 1.
- Flush while FULL with in_valid=1 (WE_M=1, WA_M=7) -> next cycle out_valid=0 and ctrl_register_file_WE_W=0. The flushed input never appears, and in_ready=1.
- Gating: load WE_M=1 and ctrl_result_M=1, then drain -> after the drain both controls read 0 while register_file_WA_W still holds the old address.
- Saturation with CNT_W=3: hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt reads 1..7 and then stays at 7.
- Asynchronous reset mid-FULL: drop rst_n between clock edges -> outputs go to 0 immediately without a clock edge. After release the state is EMPTY and stall_cnt=0.
